// File: rtl/wb_stage_if.sv
// Bus bundle for the writeback stage: upstream instruction handshake, data-cache
// read response, register-file write port and debug status.
interface wb_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
);
   localparam int RW = $clog2(NUM_REGS);

   logic                  in_valid;
   logic                  in_ready;
   logic [RW-1:0]         in_rd;
   logic                  in_reg_write;
   logic [1:0]            in_result_src;
   logic [DATA_WIDTH-1:0] in_alu_result;
   logic [DATA_WIDTH-1:0] in_pc_plus4;
   logic [DATA_WIDTH-1:0] in_imm_ext;
   logic [2:0]            in_funct3;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [RW-1:0]         wb_a3;
   logic [DATA_WIDTH-1:0] wb_wd3;
   logic                  wb_we3;
   logic [DATA_WIDTH-1:0] instret;
   logic                  err_spurious;

   modport slave (
      input  in_valid, in_rd, in_reg_write, in_result_src, in_alu_result,
             in_pc_plus4, in_imm_ext, in_funct3, mem_rvalid, mem_rdata,
      output in_ready, wb_a3, wb_wd3, wb_we3, instret, err_spurious
   );

   modport master (
      output in_valid, in_rd, in_reg_write, in_result_src, in_alu_result,
             in_pc_plus4, in_imm_ext, in_funct3, mem_rvalid, mem_rdata,
      input  in_ready, wb_a3, wb_wd3, wb_we3, instret, err_spurious
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects the retiring result, stalls loads until the data
// cache answers, extends load data and drives the register-file write port.
module wb_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   wb_stage_if.slave bus
);
   localparam int RW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_WRITE    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         a3_q, a3_d;
   logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
   logic                  we3_q, we3_d;
   logic [DATA_WIDTH-1:0] instret_q, instret_d;
   logic                  err_q, err_d;
   logic [RW-1:0]         ld_rd_q, ld_rd_d;
   logic [2:0]            ld_f3_q, ld_f3_d;
   logic [1:0]            ld_off_q, ld_off_d;

   logic                  handshake;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] sel_result;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;

   assign in_ready  = (state_q != S_WAIT_MEM);
   assign handshake = bus.in_valid && in_ready;

   always_comb begin
      sel_result = bus.in_alu_result;
      case (bus.in_result_src)
         2'b10:   sel_result = bus.in_pc_plus4;
         2'b11:   sel_result = bus.in_imm_ext;
         default: sel_result = bus.in_alu_result;
      endcase
   end

   // Lane selection uses the offset latched at accept time, not the live bus.
   always_comb begin
      ld_byte = bus.mem_rdata[7:0];
      case (ld_off_q)
         2'd1:    ld_byte = bus.mem_rdata[15:8];
         2'd2:    ld_byte = bus.mem_rdata[23:16];
         2'd3:    ld_byte = bus.mem_rdata[31:24];
         default: ld_byte = bus.mem_rdata[7:0];
      endcase
      ld_half = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (ld_f3_q)
         3'b000:  load_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default: load_ext = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      a3_d      = a3_q;
      wd3_d     = wd3_q;
      we3_d     = 1'b0;
      instret_d = instret_q;
      err_d     = err_q;
      ld_rd_d   = ld_rd_q;
      ld_f3_d   = ld_f3_q;
      ld_off_d  = ld_off_q;

      case (state_q)
         S_IDLE, S_WRITE: begin
            if (bus.mem_rvalid) err_d = 1'b1;
            if (handshake) begin
               if (bus.in_result_src == 2'b01) begin
                  state_d  = S_WAIT_MEM;
                  ld_rd_d  = bus.in_rd;
                  ld_f3_d  = bus.in_funct3;
                  ld_off_d = bus.in_alu_result[1:0];
               end else begin
                  state_d   = S_WRITE;
                  a3_d      = bus.in_rd;
                  wd3_d     = sel_result;
                  we3_d     = bus.in_reg_write && (bus.in_rd != '0);
                  instret_d = instret_q + DATA_WIDTH'(1);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_MEM: begin
            if (bus.mem_rvalid) begin
               state_d   = S_WRITE;
               a3_d      = ld_rd_q;
               wd3_d     = load_ext;
               we3_d     = (ld_rd_q != '0);
               instret_d = instret_q + DATA_WIDTH'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a3_q      <= '0;
         wd3_q     <= '0;
         we3_q     <= 1'b0;
         instret_q <= '0;
         err_q     <= 1'b0;
         ld_rd_q   <= '0;
         ld_f3_q   <= '0;
         ld_off_q  <= '0;
      end else begin
         state_q   <= state_d;
         a3_q      <= a3_d;
         wd3_q     <= wd3_d;
         we3_q     <= we3_d;
         instret_q <= instret_d;
         err_q     <= err_d;
         ld_rd_q   <= ld_rd_d;
         ld_f3_q   <= ld_f3_d;
         ld_off_q  <= ld_off_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.wb_a3        = a3_q;
   assign bus.wb_wd3       = wd3_q;
   assign bus.wb_we3       = we3_q;
   assign bus.instret      = instret_q;
   assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: hand-computed writeback values, load
// extension cases, stall behaviour, spurious responses and counter wrap.
module tb_wb_stage;
   logic clk;
   logic rst_n;

   wb_stage_if #(.DATA_WIDTH(32), .NUM_REGS(32)) bus ();

   wb_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec;
   int unsigned n_err;
   logic [31:0] exp_ir;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid      = 1'b0;
      bus.in_rd         = '0;
      bus.in_reg_write  = 1'b0;
      bus.in_result_src = 2'b00;
      bus.in_alu_result = '0;
      bus.in_pc_plus4   = '0;
      bus.in_imm_ext    = '0;
      bus.in_funct3     = '0;
      bus.mem_rvalid    = 1'b0;
      bus.mem_rdata     = '0;
   endtask

   // Unselected sources carry distinct junk so a wrong mux choice is visible.
   task automatic send(input logic [1:0] src, input logic [4:0] rd, input logic rw,
                       input logic [31:0] val, input logic [2:0] f3);
      bus.in_valid      = 1'b1;
      bus.in_result_src = src;
      bus.in_rd         = rd;
      bus.in_reg_write  = rw;
      bus.in_funct3     = f3;
      bus.in_alu_result = (src == 2'b00 || src == 2'b01) ? val : 32'h1111_1111;
      bus.in_pc_plus4   = (src == 2'b10) ? val : 32'h2222_2222;
      bus.in_imm_ext    = (src == 2'b11) ? val : 32'h3333_3333;
   endtask

   task automatic exp_write(input string tag, input logic [4:0] rd, input logic [31:0] val,
                            input logic we);
      check_eq({tag, ".we3"}, {31'd0, bus.wb_we3}, {31'd0, we});
      check_eq({tag, ".a3"},  {27'd0, bus.wb_a3},  {27'd0, rd});
      check_eq({tag, ".wd3"}, bus.wb_wd3, val);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
      send(2'b01, rd, 1'b0, {30'h0000_0400, off}, f3);
      step();
      check_eq({tag, ".rdy0"}, {31'd0, bus.in_ready}, 32'd0);
      check_eq({tag, ".we0"},  {31'd0, bus.wb_we3},   32'd0);
      send(2'b00, 5'd9, 1'b1, 32'h0000_0999, 3'b000);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq({tag, ".stall_rdy"}, {31'd0, bus.in_ready}, 32'd0);
         check_eq({tag, ".stall_we"},  {31'd0, bus.wb_we3},   32'd0);
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      step();
      exp_ir++;
      exp_write(tag, rd, exp, rd != 5'd0);
      check_eq({tag, ".instret"}, bus.instret, exp_ir);
      idle_inputs();
      step();
      check_eq({tag, ".once"},  {31'd0, bus.wb_we3},   32'd0);
      check_eq({tag, ".hold"},  {27'd0, bus.wb_a3},    {27'd0, rd});
      check_eq({tag, ".rdy1"},  {31'd0, bus.in_ready}, 32'd1);
      check_eq({tag, ".ir_nodecoy"}, bus.instret, exp_ir);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      exp_ir = '0;
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      check_eq("rst.a3",  {27'd0, bus.wb_a3}, 32'd0);
      check_eq("rst.wd3", bus.wb_wd3, 32'd0);
      check_eq("rst.we3", {31'd0, bus.wb_we3}, 32'd0);
      check_eq("rst.instret", bus.instret, 32'd0);
      check_eq("rst.err", {31'd0, bus.err_spurious}, 32'd0);
      check_eq("rst.rdy", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;

      send(2'b00, 5'd5, 1'b1, 32'h0000_1234, 3'b000);
      step();
      exp_ir++;
      exp_write("alu5", 5'd5, 32'h0000_1234, 1'b1);
      check_eq("alu5.instret", bus.instret, exp_ir);
      idle_inputs();
      step();
      exp_write("alu5.end", 5'd5, 32'h0000_1234, 1'b0);

      send(2'b00, 5'd1, 1'b1, 32'h0000_000A, 3'b000);
      step();
      exp_ir++;
      exp_write("b2b.alu", 5'd1, 32'h0000_000A, 1'b1);
      send(2'b10, 5'd2, 1'b1, 32'h0000_0104, 3'b000);
      step();
      exp_ir++;
      exp_write("b2b.pc4", 5'd2, 32'h0000_0104, 1'b1);
      send(2'b11, 5'd3, 1'b1, 32'hABC0_0000, 3'b000);
      step();
      exp_ir++;
      exp_write("b2b.imm", 5'd3, 32'hABC0_0000, 1'b1);
      check_eq("b2b.instret", bus.instret, exp_ir);
      idle_inputs();
      step();
      check_eq("b2b.end", {31'd0, bus.wb_we3}, 32'd0);

      do_load("lb",    3'b000, 2'd2, 5'd7,  32'h1280_FF00, 32'hFFFF_FF80);
      do_load("lbu",   3'b100, 2'd2, 5'd8,  32'h1280_FF00, 32'h0000_0080);
      do_load("lh2",   3'b001, 2'd2, 5'd10, 32'h1280_FF00, 32'h0000_1280);
      do_load("lh0",   3'b001, 2'd0, 5'd11, 32'h1234_8001, 32'hFFFF_8001);
      do_load("lhu0",  3'b101, 2'd0, 5'd12, 32'h1234_8001, 32'h0000_8001);
      do_load("lb3",   3'b000, 2'd3, 5'd13, 32'h7F00_0000, 32'h0000_007F);
      do_load("lw",    3'b010, 2'd0, 5'd14, 32'hCAFE_BABE, 32'hCAFE_BABE);
      do_load("f3_110", 3'b110, 2'd1, 5'd15, 32'hCAFE_BABE, 32'hCAFE_BABE);
      do_load("ld_rd0", 3'b010, 2'd0, 5'd0, 32'h5555_AAAA, 32'h5555_AAAA);

      send(2'b00, 5'd0, 1'b1, 32'h0000_DEAD, 3'b000);
      step();
      exp_ir++;
      exp_write("rd0", 5'd0, 32'h0000_DEAD, 1'b0);
      check_eq("rd0.instret", bus.instret, exp_ir);
      send(2'b00, 5'd4, 1'b0, 32'h0000_BEEF, 3'b000);
      step();
      exp_ir++;
      exp_write("nowr", 5'd4, 32'h0000_BEEF, 1'b0);
      check_eq("nowr.instret", bus.instret, exp_ir);
      idle_inputs();
      step();

      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h9999_9999;
      step();
      check_eq("spur.err", {31'd0, bus.err_spurious}, 32'd1);
      check_eq("spur.we3", {31'd0, bus.wb_we3}, 32'd0);
      check_eq("spur.wd3", bus.wb_wd3, 32'h0000_BEEF);
      idle_inputs();
      step();
      step();
      check_eq("spur.sticky", {31'd0, bus.err_spurious}, 32'd1);
      check_eq("spur.instret", bus.instret, exp_ir);

      send(2'b01, 5'd20, 1'b1, 32'h0000_0400, 3'b010);
      step();
      check_eq("rstw.wait", {31'd0, bus.in_ready}, 32'd0);
      rst_n = 1'b0;
      idle_inputs();
      step();
      exp_ir = '0;
      check_eq("rstw.rdy", {31'd0, bus.in_ready}, 32'd1);
      check_eq("rstw.a3",  {27'd0, bus.wb_a3}, 32'd0);
      check_eq("rstw.wd3", bus.wb_wd3, 32'd0);
      check_eq("rstw.we3", {31'd0, bus.wb_we3}, 32'd0);
      check_eq("rstw.instret", bus.instret, 32'd0);
      check_eq("rstw.err", {31'd0, bus.err_spurious}, 32'd0);
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD_F00D;
      step();
      check_eq("rstw.late_err", {31'd0, bus.err_spurious}, 32'd1);
      check_eq("rstw.late_we3", {31'd0, bus.wb_we3}, 32'd0);
      check_eq("rstw.late_a3",  {27'd0, bus.wb_a3}, 32'd0);
      idle_inputs();
      step();

      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      check_eq("wrap.pre", bus.instret, 32'hFFFF_FFFF);
      send(2'b00, 5'd6, 1'b1, 32'h0000_0055, 3'b000);
      step();
      check_eq("wrap.instret", bus.instret, 32'h0000_0000);
      exp_write("wrap", 5'd6, 32'h0000_0055, 1'b1);
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage that sits directly upstream of the register file and drives its single write port (A3/WD3/WE3).
- Accepts one retiring instruction per cycle from the memory stage and selects the result: ALU, load data, PC+4 or immediate.
- Loads stall the stage until the data cache returns read data. The load data is sign- or zero-extended by funct3 before the write.
- Also keeps a retired-instruction counter for debug.

Parameters:
DATA_WIDTH, 32, datapath width (only 32 is supported)
NUM_REGS, 32, register count; the rd width is $clog2(NUM_REGS)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_rd  input  5  destination register
in_reg_write  input  1  instruction writes rd
in_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate
in_alu_result  input  32  ALU result / load address
in_pc_plus4  input  32  PC+4
in_imm_ext  input  32  extended immediate (LUI)
in_funct3  input  3  load size/sign
mem_rvalid  input  1  data-cache read response valid (single-cycle pulse)
mem_rdata  input  32  data-cache read word (word-aligned)
wb_a3  output  5  to RegFile A3
wb_wd3  output  32  to RegFile WD3
wb_we3  output  1  to RegFile WE3
instret  output  32  retired-instruction count
err_spurious  output  1  sticky: mem_rvalid seen while not waiting

Behaviour:
- Reset (rst_n low at posedge): state IDLE; wb_a3=0, wb_wd3=0, wb_we3=0, instret=0, err_spurious=0.
  - Applies in any state. A pending load is abandoned.
- All outputs except in_ready are registered. in_ready is combinational: 1 in IDLE and WRITE, 0 in WAIT_MEM.
- A handshake occurs at a posedge where in_valid && in_ready.
- FSM transitions:
  - IDLE, no handshake: stay in IDLE, wb_we3=0.
  - IDLE or WRITE, handshake with result_src=01: go to WAIT_MEM.
    - Latch rd, funct3 and in_alu_result[1:0].
    - wb_we3<=0.
  - IDLE or WRITE, handshake with other result_src: go to WRITE.
    - wb_a3<=in_rd.
    - wb_wd3<=selected value (00 ALU, 10 PC+4, 11 imm).
    - wb_we3<=in_reg_write && in_rd!=0.
  - WRITE, no handshake: go to IDLE, wb_we3<=0. wb_a3 and wb_wd3 hold their values.
  - WAIT_MEM, mem_rvalid=1: go to WRITE.
    - wb_a3<=latched rd.
    - wb_wd3<=extended load data.
    - wb_we3<=(rd!=0).
    - A load always writes; in_reg_write is ignored for loads.
  - WAIT_MEM, mem_rvalid=0: stay in WAIT_MEM and hold. in_valid is ignored.
- Latency:
  - Non-load accepted at posedge k: wb_we3 is high from k to k+1. The RegFile commits on the negedge within that cycle.
  - Back-to-back non-loads sustain 1 per cycle.
  - Load: wb_we3 is high for the one cycle after the posedge that samples mem_rvalid.
- wb_we3 is never high for more than one cycle per instruction.
- Load extension, with byte lane = offset[1:0] and halfword = offset[1]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - 011/110/111: treated as LW.
- instret increments by 1 on every transition into WRITE, including transitions where wb_we3=0 (rd=0 or reg_write=0). It wraps from 0xFFFFFFFF to 0.
- mem_rvalid sampled in IDLE or WRITE: the data is ignored and err_spurious<=1. err_spurious is cleared only by reset.
- Simultaneous events:
  - In WRITE, a handshake and the end of the write coincide. The new instruction replaces the outputs at the same edge.
  - mem_rvalid in WAIT_MEM alongside in_valid: the incoming instruction is not accepted, because in_ready=0 that cycle.

Test Plan:
- Reset, then ALU instr rd=5, result 0x1234 -> next cycle wb_a3=5, wb_wd3=0x1234, wb_we3=1 for exactly one cycle; instret=1.
- Three back-to-back instrs: result_src 00/10/11, rd 1,2,3, values 0xA, 0x104, 0xABC00000 -> wb_we3 high for 3 consecutive cycles with matching a3/wd3; instret=3.
- LB, offset 2, mem_rdata=0x1280FF00, rvalid after 4 cycles -> in_ready low for 4 cycles, then wb_wd3=0xFFFFFF80, rd written once. Same with LBU -> 0x00000080. LH offset 2 -> 0x00001280.
- ALU instr rd=0 value 0xDEAD -> wb_we3 stays 0, instret increments. Load with rd=0 -> waits for rvalid, no write, returns to IDLE.
- mem_rvalid pulsed in IDLE -> no write, err_spurious=1 and sticky.
- rst_n low during WAIT_MEM -> IDLE with all outputs 0. Later rvalid -> err_spurious=1.
- Preload instret=0xFFFFFFFF via 2^32 retires or force -> one more retire gives 0.
